// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the cache-to-memory arbiter.
// Port identities and FSM states are used by both the top and the round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_D = 1'b0,
        PORT_I = 1'b1
    } port_t;

    localparam int ADDR_W_DEF      = 6;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 64;

    function automatic port_t other_port(input port_t p);
        return (p == PORT_D) ? PORT_I : PORT_D;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin choice: a lone requester wins, a tie goes to the port
// that was not served last. Purely combinational.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic req_d,
    input  logic req_i,
    input  logic last,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req_d | req_i;
        if (req_d && req_i) begin
            grant = other_port(port_t'(last));
        end else if (req_d) begin
            grant = PORT_D;
        end else begin
            grant = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the dcache (read/write) and the icache
// (read-only); one block transfer at a time, round-robin on ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_writedata,
    output logic [DATA_W-1:0] d_mem_readdata,
    output logic              d_mem_busywait,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [DATA_W-1:0] i_mem_readdata,
    output logic              i_mem_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    port_t              grant;
    port_t              last;
    logic               op_write;
    logic [CNT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]  d_rdata;
    logic [DATA_W-1:0]  i_rdata;

    logic req_d;
    logic req_i;
    logic pick_grant;
    logic pick_valid;
    logic timeout_hit;
    logic mem_phase;

    assign req_d = d_mem_read | d_mem_write;
    assign req_i = i_mem_read;

    arb_rr_pick u_pick (
        .req_d (req_d),
        .req_i (req_i),
        .last  (last),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // The operation kind is latched at grant so a requester that lets go
    // mid-transfer cannot change what memory is being asked to do.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            grant       <= PORT_D;
            last        <= PORT_I;
            op_write    <= 1'b0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            d_rdata     <= '0;
            i_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= ISSUE;
                        grant    <= port_t'(pick_grant);
                        last     <= port_t'(pick_grant);
                        op_write <= (port_t'(pick_grant) == PORT_D) && d_mem_write;
                        wait_cnt <= '0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!mem_busywait) begin
                        state <= RESP;
                        if (!op_write) begin
                            if (grant == PORT_D) d_rdata <= mem_readdata;
                            else                 i_rdata <= mem_readdata;
                        end
                    end else if (timeout_hit) begin
                        // Abort with a zero block so the requester never consumes stale data.
                        state       <= RESP;
                        err_timeout <= 1'b1;
                        if (grant == PORT_D) d_rdata <= '0;
                        else                 i_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_phase = (state == ISSUE) || (state == WAIT);

    always_comb begin
        mem_read      = mem_phase && !op_write;
        mem_write     = mem_phase && op_write;
        mem_address   = '0;
        mem_writedata = '0;
        if (mem_phase) begin
            mem_address = (grant == PORT_D) ? d_mem_address : i_mem_address;
            if (op_write) begin
                mem_writedata = d_mem_writedata;
            end
        end
    end

    assign d_mem_busywait = req_d && !((state == RESP) && (grant == PORT_D));
    assign i_mem_busywait = req_i && !((state == RESP) && (grant == PORT_I));
    assign d_mem_readdata = d_rdata;
    assign i_mem_readdata = i_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected completions, a
// negedge monitor predicts grants by round-robin and checks every completion.
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          CLK;
    logic          RESET;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [AW-1:0] d_mem_address;
    logic [DW-1:0] d_mem_writedata;
    logic [DW-1:0] d_mem_readdata;
    logic          d_mem_busywait;
    logic          i_mem_read;
    logic [AW-1:0] i_mem_address;
    logic [DW-1:0] i_mem_readdata;
    logic          i_mem_busywait;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata;
    logic          mem_busywait;
    logic          err_timeout;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .d_mem_read      (d_mem_read),
        .d_mem_write     (d_mem_write),
        .d_mem_address   (d_mem_address),
        .d_mem_writedata (d_mem_writedata),
        .d_mem_readdata  (d_mem_readdata),
        .d_mem_busywait  (d_mem_busywait),
        .i_mem_read      (i_mem_read),
        .i_mem_address   (i_mem_address),
        .i_mem_readdata  (i_mem_readdata),
        .i_mem_busywait  (i_mem_busywait),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_busywait    (mem_busywait),
        .err_timeout     (err_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: mem_arr is what the memory model holds, ref_mem is what it should hold.
    logic [DW-1:0] mem_arr [64];
    logic [DW-1:0] ref_mem [64];

    typedef struct packed {
        logic          wr;
        logic          to;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t d_exp_q[$];
    exp_t i_exp_q[$];
    bit   grant_q[$];   // 0 = dcache, 1 = icache

    bit mem_stuck = 1'b0;
    bit rand_lat  = 1'b0;
    int fixed_lat = 2;

    // Memory model: busy for lat cycles after the request's first cycle, then one ready edge.
    initial begin
        bit            active;
        int            m;
        int            lat;
        logic [AW-1:0] maddr;
        active       = 1'b0;
        m            = 0;
        lat          = 0;
        maddr        = '0;
        mem_busywait = 1'b0;
        mem_readdata = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (RESET) begin
                active       = 1'b0;
                mem_busywait = 1'b0;
            end else if (!active) begin
                if (mem_read || mem_write) begin
                    active = 1'b1;
                    m      = -1;
                    lat    = rand_lat ? int'($urandom_range(0, 5)) : fixed_lat;
                    maddr  = mem_address;
                    if (mem_write) mem_arr[maddr] = mem_writedata;
                    mem_readdata = $urandom;
                    mem_busywait = 1'b1;
                end
            end else if (!(mem_read || mem_write)) begin
                active       = 1'b0;
                mem_busywait = 1'b0;
            end else begin
                m++;
                mem_busywait = mem_stuck || (m < lat);
                mem_readdata = mem_busywait ? $urandom : mem_arr[maddr];
            end
        end
    end

    // Monitor: predicts each grant from the requests seen in IDLE and checks completions.
    bit            ref_last   = 1'b1;
    logic [DW-1:0] ref_d_last = '0;
    logic [DW-1:0] ref_i_last = '0;
    bit            prev_mreq  = 1'b0;
    bit            pd         = 1'b0;
    bit            pi         = 1'b0;

    always @(negedge CLK) begin
        bit   win;
        bit   exp_w;
        bit   g;
        bit   dserv;
        bit   iserv;
        exp_t e;
        if (RESET) begin
            ref_last   = 1'b1;
            ref_d_last = '0;
            ref_i_last = '0;
            grant_q.delete();
        end else begin
            if ((mem_read || mem_write) && !prev_mreq) begin
                if (!pd && !pi) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_without_request: mem_read=%0b mem_write=%0b", mem_read, mem_write);
                end else begin
                    win      = (pd && pi) ? !ref_last : pi;
                    ref_last = win;
                    grant_q.push_back(win);
                    exp_w = !win && d_mem_write;
                    chk("grant_mem_write", mem_write, exp_w);
                    chk("grant_mem_read", mem_read, !exp_w);
                    chk("grant_addr", mem_address, win ? i_mem_address : d_mem_address);
                    if (exp_w) chk("grant_wdata", mem_writedata, d_mem_writedata);
                end
            end
            dserv = (d_mem_read || d_mem_write) && !d_mem_busywait;
            iserv = i_mem_read && !i_mem_busywait;
            if (dserv && iserv) begin
                checks++;
                failures++;
                $display("FAIL both_served: d and i busywait low together");
            end
            if (dserv) begin
                if (grant_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d_done_no_grant: completion without predicted grant");
                end else begin
                    g = grant_q.pop_front();
                    chk("d_done_port", 64'(g), 64'(0));
                end
                if (d_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d_done_unexpected: no outstanding dcache request");
                end else begin
                    e = d_exp_q.pop_front();
                    if (e.to) begin
                        chk("d_timeout_rdata", d_mem_readdata, '0);
                        ref_d_last = '0;
                    end else if (e.wr) begin
                        chk("d_write_rdata_kept", d_mem_readdata, ref_d_last);
                    end else begin
                        chk("d_read_rdata", d_mem_readdata, e.data);
                        ref_d_last = e.data;
                    end
                end
            end
            if (iserv) begin
                if (grant_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL i_done_no_grant: completion without predicted grant");
                end else begin
                    g = grant_q.pop_front();
                    chk("i_done_port", 64'(g), 64'(1));
                end
                if (i_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL i_done_unexpected: no outstanding icache request");
                end else begin
                    e = i_exp_q.pop_front();
                    chk("i_read_rdata", i_mem_readdata, e.to ? '0 : e.data);
                    ref_i_last = e.to ? '0 : e.data;
                end
            end
        end
        prev_mreq = mem_read || mem_write;
        pd        = d_mem_read || d_mem_write;
        pi        = i_mem_read;
    end

    // Called just after a rising edge; returns once the request has been dropped.
    task automatic d_txn(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit to,
                         output int n, output int hits, output logic [DW-1:0] rdat);
        exp_t e;
        e.wr   = wr;
        e.to   = to;
        e.addr = a;
        e.data = to ? '0 : (wr ? wd : ref_mem[a]);
        if (wr && !to) ref_mem[a] = wd;
        d_exp_q.push_back(e);
        d_mem_read      = rd;
        d_mem_write     = wr;
        d_mem_address   = a;
        d_mem_writedata = wd;
        n    = 0;
        hits = 0;
        do begin
            @(negedge CLK);
            n++;
            if ((mem_read || mem_write) && mem_address == a) hits++;
        end while (d_mem_busywait && n < 300);
        if (d_mem_busywait) begin
            checks++; failures++;
            $display("FAIL d_txn_stall: busywait still %0b after %0d cycles", d_mem_busywait, n);
        end
        rdat = d_mem_readdata;
        @(posedge CLK);
        #1;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
    endtask

    task automatic i_txn(input logic [AW-1:0] a, output int n, output logic [DW-1:0] rdat);
        exp_t e;
        e.wr   = 1'b0;
        e.to   = 1'b0;
        e.addr = a;
        e.data = ref_mem[a];
        i_exp_q.push_back(e);
        i_mem_read    = 1'b1;
        i_mem_address = a;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (i_mem_busywait && n < 300);
        if (i_mem_busywait) begin
            checks++; failures++;
            $display("FAIL i_txn_stall: busywait still %0b after %0d cycles", i_mem_busywait, n);
        end
        rdat = i_mem_readdata;
        @(posedge CLK);
        #1;
        i_mem_read = 1'b0;
    endtask

    int            nd, ni, hd, n2;
    logic [DW-1:0] rdd, rdi;

    initial begin
        logic [DW-1:0] v;
        for (int a = 0; a < 64; a++) begin
            v          = $urandom;
            mem_arr[a] = v;
            ref_mem[a] = v;
        end
        RESET           = 1'b1;
        d_mem_read      = 1'b0;
        d_mem_write     = 1'b0;
        d_mem_address   = '0;
        d_mem_writedata = '0;
        i_mem_read      = 1'b0;
        i_mem_address   = '0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        @(negedge CLK);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_d_rdata", d_mem_readdata, '0);
        chk("rst_i_rdata", i_mem_readdata, '0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_d_busy", d_mem_busywait, 1'b0);
        chk("rst_i_busy", i_mem_busywait, 1'b0);
        @(posedge CLK);
        #1;

        // Tie straight after reset: dcache first, icache stalled through it.
        fixed_lat = 2;
        fork
            d_txn(1'b1, 1'b0, 6'd10, '0, 1'b0, nd, hd, rdd);
            i_txn(6'd40, ni, rdi);
        join
        chk("tie1_d_cycles", nd, 6);
        chk("tie1_i_cycles", ni, 12);

        // Single dcache read with five busy cycles.
        fixed_lat  = 5;
        mem_arr[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        d_txn(1'b1, 1'b0, 6'd5, '0, 1'b0, nd, hd, rdd);
        chk("rd5_busy_cycles", nd, 9);
        chk("rd5_addr_cycles", hd, 7);
        chk("rd5_rdata", rdd, 32'hDEADBEEF);

        // Second tie: dcache was served last, so icache wins.
        fixed_lat = 2;
        fork
            d_txn(1'b1, 1'b0, 6'd12, '0, 1'b0, nd, hd, rdd);
            i_txn(6'd33, ni, rdi);
        join
        chk("tie2_i_cycles", ni, 6);
        chk("tie2_d_cycles", nd, 12);

        // Write, then read back through memory; then read+write together.
        d_txn(1'b0, 1'b1, 6'h2A, 32'h01234567, 1'b0, nd, hd, rdd);
        chk("wr_addr_cycles", hd, 4);
        d_txn(1'b1, 1'b0, 6'h2A, '0, 1'b0, nd, hd, rdd);
        chk("wr_readback", rdd, 32'h01234567);
        d_txn(1'b1, 1'b1, 6'h11, 32'hCAFEF00D, 1'b0, nd, hd, rdd);
        d_txn(1'b1, 1'b0, 6'h11, '0, 1'b0, nd, hd, rdd);
        chk("rw_readback", rdd, 32'hCAFEF00D);

        // Memory never becomes ready.
        mem_stuck = 1'b1;
        d_txn(1'b1, 1'b0, 6'd3, '0, 1'b1, nd, hd, rdd);
        mem_stuck = 1'b0;
        chk("to_busy_cycles", nd, 11);
        chk("to_addr_cycles", hd, 9);
        chk("to_rdata", rdd, '0);
        chk("to_err", err_timeout, 1'b1);

        // Randomised traffic: dcache writes stay in the low half, icache reads the high half.
        rand_lat = 1'b1;
        fork
            begin
                int            dn, dh;
                logic [DW-1:0] dr;
                for (int t = 0; t < 50; t++) begin
                    int op;
                    op = int'($urandom_range(0, 3));
                    if (op < 2) d_txn(1'b1, 1'b0, 6'($urandom_range(0, 63)), '0, 1'b0, dn, dh, dr);
                    else        d_txn(op == 3, 1'b1, 6'($urandom_range(0, 31)), $urandom, 1'b0, dn, dh, dr);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge CLK);
                        #1;
                    end
                end
            end
            begin
                int            inn;
                logic [DW-1:0] ir;
                for (int t = 0; t < 50; t++) begin
                    i_txn(6'($urandom_range(32, 63)), inn, ir);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge CLK);
                        #1;
                    end
                end
            end
        join
        rand_lat = 1'b0;

        // Reset while waiting on memory; the held request is served afresh afterwards.
        fixed_lat = 6;
        fork
            d_txn(1'b1, 1'b0, 6'd7, '0, 1'b0, nd, hd, rdd);
            begin
                repeat (3) @(negedge CLK);
                chk("err_sticky", err_timeout, 1'b1);
                @(posedge CLK);
                #1 RESET = 1'b1;
                @(posedge CLK);
                #1 RESET = 1'b0;
                @(negedge CLK);
                chk("midrst_mem_read", mem_read, 1'b0);
                chk("midrst_mem_write", mem_write, 1'b0);
                chk("midrst_d_rdata", d_mem_readdata, '0);
                chk("midrst_i_rdata", i_mem_readdata, '0);
                chk("midrst_err", err_timeout, 1'b0);
                chk("midrst_d_busy", d_mem_busywait, 1'b1);
            end
        join
        chk("postrst_rdata", rdd, ref_mem[7]);
        fixed_lat = 1;
        i_txn(6'd50, n2, rdi);
        chk("postrst_i_rdata", rdi, ref_mem[50]);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
